// File: rtl/soc_io_bridge_if.sv
// CPU-side memory bus of the IO bridge (FemtoRV32 style).
// The master drives the request; the slave returns read data and busy flags.
interface soc_io_bridge_if;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic        data_access;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        mem_wbusy;

  modport master (
    output mem_address, mem_wdata, mem_wmask, mem_rstrb, data_access,
    input  mem_rdata, mem_rbusy, mem_wbusy
  );

  modport slave (
    input  mem_address, mem_wdata, mem_wmask, mem_rstrb, data_access,
    output mem_rdata, mem_rbusy, mem_wbusy
  );
endinterface

// File: rtl/soc_io_bridge.sv
// IO bridge between the CPU memory bus and NUM_DEV byte-wide peripherals.
// Decodes the IO window, steers the write byte, pulses one-cycle device
// strobes, holds busy until the device is ready and flags timeouts and
// unmapped accesses on a sticky bus_error.
module soc_io_bridge #(
  parameter int NUM_DEV = 4,
  parameter int IO_BIT  = 22,
  parameter int DEV_AW  = 8,
  parameter int SEL_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  soc_io_bridge_if.slave       bus,
  output logic [NUM_DEV-1:0]   dev_cs,
  output logic [NUM_DEV-1:0]   dev_rd,
  output logic [NUM_DEV-1:0]   dev_wr,
  output logic [DEV_AW-1:0]    dev_addr,
  output logic [7:0]           dev_wdata,
  input  logic [8*NUM_DEV-1:0] dev_rdata,
  input  logic [NUM_DEV-1:0]   dev_ready,
  output logic                 bus_error,
  input  logic                 err_clear
);

  // A zero TIMEOUT still needs a one-bit timer so the declarations stay legal.
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMAX = TMR_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, ERR} state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic [31:0]        rdata, rdata_nxt;
  logic               rbusy, rbusy_nxt;
  logic               wbusy, wbusy_nxt;
  logic [NUM_DEV-1:0] cs_nxt, rd_nxt, wr_nxt;
  logic [DEV_AW-1:0]  addr_nxt;
  logic [7:0]         wdata_nxt;
  logic               err_nxt;

  logic               is_wr;
  logic               req;
  logic [SEL_W-1:0]   sel;
  logic [NUM_DEV-1:0] dec;
  logic [7:0]         wbyte;
  logic [7:0]         rbyte;
  logic               ready_hit;
  logic               timed_out;

  assign bus.mem_rdata = rdata;
  assign bus.mem_rbusy = rbusy;
  assign bus.mem_wbusy = wbusy;

  // Request decode, byte steering and selection of the active device's ready/data.
  always_comb begin
    is_wr = |bus.mem_wmask;
    req   = bus.mem_address[IO_BIT] & bus.data_access & (bus.mem_rstrb | is_wr);
    sel   = bus.mem_address[DEV_AW +: SEL_W];
    dec   = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      dec[i] = (32'(sel) == 32'(i));
    end
    // Lowest enabled byte lane wins.
    if (bus.mem_wmask[0])      wbyte = bus.mem_wdata[7:0];
    else if (bus.mem_wmask[1]) wbyte = bus.mem_wdata[15:8];
    else if (bus.mem_wmask[2]) wbyte = bus.mem_wdata[23:16];
    else                       wbyte = bus.mem_wdata[31:24];
    // dev_cs is one-hot during a transaction, so an OR-mux picks the active device.
    rbyte = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (dev_cs[i]) rbyte = rbyte | dev_rdata[8*i +: 8];
    end
    ready_hit = |(dev_ready & dev_cs);
    timed_out = (TIMEOUT != 0) && (timer == TMAX);
  end

  // Next-state and next-output logic of the transaction FSM.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    rdata_nxt = rdata;
    rbusy_nxt = rbusy;
    wbusy_nxt = wbusy;
    cs_nxt    = dev_cs;
    rd_nxt    = '0;
    wr_nxt    = '0;
    addr_nxt  = dev_addr;
    wdata_nxt = dev_wdata;
    err_nxt   = err_clear ? 1'b0 : bus_error;
    unique case (state)
      IDLE: begin
        if (req) begin
          rbusy_nxt = ~is_wr;
          wbusy_nxt = is_wr;
          if (|dec) begin
            state_nxt = is_wr ? WR_WAIT : RD_WAIT;
            cs_nxt    = dec;
            rd_nxt    = is_wr ? '0 : dec;
            wr_nxt    = is_wr ? dec : '0;
            addr_nxt  = bus.mem_address[DEV_AW-1:0];
            wdata_nxt = wbyte;
            timer_nxt = '0;
          end else begin
            state_nxt = ERR;
            err_nxt   = 1'b1;
            if (!is_wr) rdata_nxt = 32'hFFFF_FFFF;
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (ready_hit) begin
          state_nxt = IDLE;
          rbusy_nxt = 1'b0;
          wbusy_nxt = 1'b0;
          cs_nxt    = '0;
          if (state == RD_WAIT) rdata_nxt = {24'b0, rbyte};
        end else if (timed_out) begin
          state_nxt = IDLE;
          rbusy_nxt = 1'b0;
          wbusy_nxt = 1'b0;
          cs_nxt    = '0;
          err_nxt   = 1'b1;
          if (state == RD_WAIT) rdata_nxt = 32'hFFFF_FFFF;
        end else if (timer != TMAX) begin
          timer_nxt = timer + 1'b1;
        end
      end
      ERR: begin
        state_nxt = IDLE;
        rbusy_nxt = 1'b0;
        wbusy_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset clears everything and aborts any transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      rdata     <= '0;
      rbusy     <= 1'b0;
      wbusy     <= 1'b0;
      dev_cs    <= '0;
      dev_rd    <= '0;
      dev_wr    <= '0;
      dev_addr  <= '0;
      dev_wdata <= '0;
      bus_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      rdata     <= rdata_nxt;
      rbusy     <= rbusy_nxt;
      wbusy     <= wbusy_nxt;
      dev_cs    <= cs_nxt;
      dev_rd    <= rd_nxt;
      dev_wr    <= wr_nxt;
      dev_addr  <= addr_nxt;
      dev_wdata <= wdata_nxt;
      bus_error <= err_nxt;
    end
  end

endmodule
